// File: rtl/flag_int_ctrl_if.sv
// rtl/flag_int_ctrl_if.sv - control-unit side bundle of the flag/interrupt controller
interface flag_int_ctrl_if #(
    parameter int SHADOW_DEPTH = 4
);
    localparam int DW = $clog2(SHADOW_DEPTH + 1);

    logic          intr;
    logic          c_in;
    logic          z_in;
    logic          flg_c_ld;
    logic          flg_z_ld;
    logic          flg_c_set;
    logic          flg_c_clr;
    logic          i_set;
    logic          i_clr;
    logic          instr_done;
    logic          retie;
    logic          int_ack;
    logic          int_req;
    logic          isr_ld;
    logic          c_flag;
    logic          z_flag;
    logic          i_flag;
    logic [DW-1:0] depth;
    logic          stk_err;

    modport master (
        output intr, c_in, z_in, flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr,
               i_set, i_clr, instr_done, retie, int_ack,
        input  int_req, isr_ld, c_flag, z_flag, i_flag, depth, stk_err
    );

    modport slave (
        input  intr, c_in, z_in, flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr,
               i_set, i_clr, instr_done, retie, int_ack,
        output int_req, isr_ld, c_flag, z_flag, i_flag, depth, stk_err
    );
endinterface

// File: rtl/flag_int_ctrl.sv
// rtl/flag_int_ctrl.sv - C/Z/I flag owner with interrupt sequencing and {C,Z} shadow stack
module flag_int_ctrl #(
    parameter int SHADOW_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    flag_int_ctrl_if.slave bus
);
    localparam int DW = $clog2(SHADOW_DEPTH + 1);
    localparam int SLOTS = 1 << DW;
    localparam logic [DW-1:0] DMAX = DW'(SHADOW_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, SAVE} state_t;

    state_t        state;
    logic          intr_q;
    logic          pending;
    logic          int_req;
    logic          isr_ld;
    logic          c_flag;
    logic          z_flag;
    logic          i_flag;
    logic [DW-1:0] depth;
    logic          stk_err;
    // Sized to the full depth-counter range so depth indexes it without truncation.
    logic [1:0]    stk [0:SLOTS-1];

    logic          rise;
    logic          entry;
    logic          pop;
    logic          full;
    logic          empty;
    logic [DW-1:0] top_idx;
    logic [1:0]    top;

    assign rise    = bus.intr & ~intr_q;
    assign entry   = (state == REQ) && bus.int_ack;
    assign pop     = (state == IDLE) && bus.retie;
    assign full    = (depth == DMAX);
    assign empty   = (depth == '0);
    assign top_idx = depth - DW'(1);
    assign top     = stk[top_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            intr_q  <= 1'b0;
            pending <= 1'b0;
            int_req <= 1'b0;
            isr_ld  <= 1'b0;
            c_flag  <= 1'b0;
            z_flag  <= 1'b0;
            i_flag  <= 1'b0;
            depth   <= '0;
            stk_err <= 1'b0;
            for (int k = 0; k < SLOTS; k++) begin
                stk[k] <= 2'b00;
            end
        end else begin
            intr_q  <= bus.intr;
            pending <= rise | (pending & ~entry);

            case (state)
                IDLE: begin
                    if (pending && i_flag && bus.instr_done) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.int_ack) begin
                        state   <= SAVE;
                        int_req <= 1'b0;
                        isr_ld  <= 1'b1;
                    end
                end
                SAVE: begin
                    state  <= IDLE;
                    isr_ld <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                    isr_ld  <= 1'b0;
                end
            endcase

            // Entry and RETIE are mutually exclusive (REQ vs IDLE), so one depth update at most.
            if (entry) begin
                if (!full) begin
                    stk[depth] <= {c_flag, z_flag};
                    depth      <= depth + DW'(1);
                end else begin
                    stk_err <= 1'b1;
                end
            end
            if (pop) begin
                if (!empty) depth <= top_idx;
                else        stk_err <= 1'b1;
            end

            if (pop && !empty)      c_flag <= top[1];
            else if (bus.flg_c_clr) c_flag <= 1'b0;
            else if (bus.flg_c_set) c_flag <= 1'b1;
            else if (bus.flg_c_ld)  c_flag <= bus.c_in;

            if (pop && !empty)      z_flag <= top[0];
            else if (bus.flg_z_ld)  z_flag <= bus.z_in;

            if (entry)              i_flag <= 1'b0;
            else if (pop)           i_flag <= 1'b1;
            else if (bus.i_clr)     i_flag <= 1'b0;
            else if (bus.i_set)     i_flag <= 1'b1;
        end
    end

    assign bus.int_req = int_req;
    assign bus.isr_ld  = isr_ld;
    assign bus.c_flag  = c_flag;
    assign bus.z_flag  = z_flag;
    assign bus.i_flag  = i_flag;
    assign bus.depth   = depth;
    assign bus.stk_err = stk_err;
endmodule

// File: doc/flag_int_ctrl.md
# flag_int_ctrl

Flag and interrupt sequencing controller for the MCU. It owns the C, Z and I (interrupt-enable) flags and latches interrupt requests, handshaking with the control unit at instruction boundaries. It saves {C,Z} to a shadow stack on interrupt entry and restores them on RETIE. It sits between the control unit's flag-control outputs and the ALU/branch logic that consumes the flags.

## Interface
Parameters:
- SHADOW_DEPTH, 4, number of {C,Z} entries in the shadow stack (≥1)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces the reset state below
- intr  in  1  external interrupt line, already synchronized; rising edge requests interrupt
- c_in, z_in  in  1  ALU carry/zero results
- flg_c_ld, flg_z_ld  in  1  load C/Z from c_in/z_in
- flg_c_set, flg_c_clr  in  1  SEC/CLC
- i_set, i_clr  in  1  SEI/CLI
- instr_done  in  1  one-cycle pulse: current instruction completes this cycle (boundary)
- retie  in  1  one-cycle pulse: RETIE executing
- int_ack  in  1  control unit accepts int_req
- int_req  out  1  interrupt request to control unit
- isr_ld  out  1  one-cycle pulse: PC loads ISR vector
- c_flag, z_flag, i_flag  out  1  current flags
- depth  out  $clog2(SHADOW_DEPTH+1)  shadow entries in use
- stk_err  out  1  sticky over/underflow indicator

## Operation
- Reset: state IDLE; c_flag=z_flag=i_flag=0; pending=0; intr_q=0; depth=0; stack contents 0; int_req=isr_ld=stk_err=0.
- Edge detect: intr_q registers intr; rising edge = intr & ~intr_q sets pending. Pending persists until cleared by entry; a set in the same cycle as a clear wins (pending stays 1).
- FSM:
  - IDLE: if pending & i_flag & instr_done → REQ. int_ack in IDLE ignored.
  - REQ: int_req=1. On int_ack → SAVE, and on that same edge: push {c_flag,z_flag} (if depth<SHADOW_DEPTH, depth+1; else no push, stk_err←1), i_flag←0, pending←0.
  - SAVE: isr_ld=1 for exactly one cycle → IDLE.
- RETIE (honored in IDLE only; ignored in REQ/SAVE): if depth>0, {c_flag,z_flag}←top, depth−1; if depth==0, C/Z unchanged, stk_err←1. i_flag←1 in both cases.
- C precedence: reset > RETIE restore > flg_c_clr > flg_c_set > flg_c_ld > hold.
- Z precedence: reset > RETIE restore > flg_z_ld > hold.
- I precedence: reset > entry clear (REQ&int_ack) > RETIE set > i_clr > i_set > hold.
- Nesting: ISR may execute SEI; a further pending interrupt then re-enters and pushes again, stack is LIFO.
- stk_err cleared only by reset.

## Timing
- Flag updates visible the cycle after the controlling pulse.
- intr rising edge at cycle n → pending=1 at n+1.
- instr_done with conditions met at cycle n → int_req=1 from n+1 until the edge sampling int_ack.
- int_ack at cycle m → isr_ld=1 and i_flag=0 during m+1; IDLE at m+2.
- Conditions for IDLE→REQ sampled on the instr_done cycle only; I cleared or pending absent then = no request until next boundary.
- Asynchronous reset mid-REQ/SAVE aborts immediately: int_req/isr_ld drop with reset, no push completes.

## Test plan
- Reset mid-REQ (int_req=1) → int_req=0 immediately, depth=0, all flags 0, state IDLE after release.
- i_flag=1, C=1 Z=0, intr rise, instr_done → int_req next cycle; int_ack → isr_ld 1 cycle, i_flag=0, depth=1; RETIE → C=1 Z=0 restored, i_flag=1, depth=0.
- i_flag=0, intr rise, 3 instr_done pulses → no int_req, pending held; SEI then instr_done → int_req asserted.
- Same cycle flg_c_set=1, flg_c_clr=1, flg_c_ld with c_in=1 → C=0; RETIE with stack top C=1 alongside flg_c_clr → C=1.
- SHADOW_DEPTH=4, five nested entries with distinct {C,Z} → depth saturates at 4, stk_err=1; four RETIEs pop 4th..1st values in order; fifth RETIE leaves flags unchanged, i_flag=1.
- intr rise on the int_ack edge → pending remains 1 after entry; second request after SEI+instr_done.
